// File: rtl/nibble_serial_adder.sv
// Nibble-serial 32-bit adder/subtractor.
// One 4-bit ripple cell processes nibbles LSB first over eight RUN cycles.
module nibble_serial_adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        sub,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        carry_out,
    output logic        overflow
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] acc;
    logic        carry;
    logic [2:0]  cnt;

    logic [3:0]  nib_sum;
    logic [4:0]  c;
    logic [31:0] acc_nxt;

    // Single 4-bit ripple cell; internal carries kept for overflow detection
    always_comb begin
        c       = 5'd0;
        nib_sum = 4'd0;
        c[0]    = carry;
        for (int i = 0; i < 4; i++) begin
            nib_sum[i] = op_a[i] ^ op_b[i] ^ c[i];
            c[i+1]     = (op_a[i] & op_b[i]) | (c[i] & (op_a[i] ^ op_b[i]));
        end
        acc_nxt = {nib_sum, acc[31:4]};
    end

    // Control FSM, serial datapath and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= 32'd0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            op_a      <= 32'd0;
            op_b      <= 32'd0;
            acc       <= 32'd0;
            carry     <= 1'b0;
            cnt       <= 3'd0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= RUN;
                        busy  <= 1'b1;
                        op_a  <= a;
                        op_b  <= sub ? ~b : b;
                        carry <= sub;
                        cnt   <= 3'd0;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> 4;
                    op_b  <= op_b >> 4;
                    carry <= c[4];
                    acc   <= acc_nxt;
                    cnt   <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        result    <= acc_nxt;
                        carry_out <= c[4];
                        overflow  <= c[3] ^ c[4];
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
